// File: rtl/multicycle_control_unit_if.sv
// Memory handshake bundle between the multicycle control unit and memory.
//   mem_req   : access request, held by the control unit until mem_ready
//   mem_we    : write qualifier, meaningful only while mem_req is high
//   mem_ready : completion strobe returned by memory for the current request
// master = control unit side, slave = memory side.
interface multicycle_control_unit_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-style control unit: sequences FETCH, DECODE, EXECUTE,
// MEMORY, WRITEBACK for R, I-ALU, LOAD and STORE instructions and parks in a
// sticky TRAP state on an unknown opcode or a memory wait timeout.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   mem (master)        : mem_req / mem_we out, mem_ready in
//   opcode/funct3/funct7_5 : instruction fields, sampled in DECODE
//   ir_write, pc_write  : load IR / advance PC, pulsed on fetch completion
//   alu_src_b, alu_op   : ALU operand select and operation code
//   reg_write, wb_sel   : register write enable and writeback source
//   state               : current FSM state code
//   illegal             : sticky trap flag
//   retired             : count of completed instructions (wraps)
module multicycle_control_unit #(
  parameter int ALU_OP_W = 4,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  multicycle_control_unit_if.master      mem,
  input  logic [6:0]                     opcode,
  input  logic [2:0]                     funct3,
  input  logic                           funct7_5,
  output logic                           ir_write,
  output logic                           pc_write,
  output logic                           alu_src_b,
  output logic [ALU_OP_W-1:0]            alu_op,
  output logic                           reg_write,
  output logic                           wb_sel,
  output logic [2:0]                     state,
  output logic                           illegal,
  output logic [CNT_W-1:0]               retired
);

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd5
  } state_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // Counter only needs to reach TIMEOUT-1: the final permitted cycle.
  localparam int              WAIT_W    = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e             state_r;
  state_e             state_nxt_s;
  logic [6:0]         op_r;
  logic [2:0]         f3_r;
  logic               f75_r;
  logic [WAIT_W-1:0]  wait_r;
  logic               illegal_r;
  logic [CNT_W-1:0]   retired_r;

  logic               is_r_s;
  logic               is_i_s;
  logic               is_load_s;
  logic               is_store_s;
  logic               waiting_s;
  logic               retire_s;
  logic [3:0]         alu_code_s;
  logic               mem_req_s;
  logic               mem_we_s;
  logic               ir_write_s;
  logic               pc_write_s;
  logic               alu_src_b_s;
  logic [3:0]         alu_op_s;
  logic               reg_write_s;
  logic               wb_sel_s;

  // Instruction class from the fields latched in DECODE.
  assign is_r_s     = (op_r == OP_R);
  assign is_i_s     = (op_r == OP_I);
  assign is_load_s  = (op_r == OP_LOAD);
  assign is_store_s = (op_r == OP_STORE);
  assign waiting_s  = (state_r == ST_FETCH) || (state_r == ST_MEMORY);

  // ALU code: shifts-right in I-ALU keep funct7_5 (SRAI vs SRLI); other I-ALU ignore it.
  always_comb begin
    alu_code_s = 4'b0000;
    if (is_r_s) begin
      alu_code_s = {f75_r, f3_r};
    end else if (is_i_s) begin
      if (f3_r == 3'b101) begin
        alu_code_s = {f75_r, f3_r};
      end else begin
        alu_code_s = {1'b0, f3_r};
      end
    end else begin
      alu_code_s = 4'b0000;
    end
  end

  // Next-state and per-state control outputs.
  always_comb begin
    state_nxt_s = state_r;
    mem_req_s   = 1'b0;
    mem_we_s    = 1'b0;
    ir_write_s  = 1'b0;
    pc_write_s  = 1'b0;
    alu_src_b_s = 1'b0;
    alu_op_s    = 4'b0000;
    reg_write_s = 1'b0;
    wb_sel_s    = 1'b0;
    retire_s    = 1'b0;
    case (state_r)
      ST_FETCH: begin
        mem_req_s = 1'b1;
        // Completion on the final permitted cycle wins over timeout.
        if (mem.mem_ready) begin
          ir_write_s  = 1'b1;
          pc_write_s  = 1'b1;
          state_nxt_s = ST_DECODE;
        end else if (wait_r == WAIT_LAST) begin
          state_nxt_s = ST_TRAP;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_R, OP_I, OP_LOAD, OP_STORE: state_nxt_s = ST_EXECUTE;
          default:                       state_nxt_s = ST_TRAP;
        endcase
      end
      ST_EXECUTE: begin
        alu_src_b_s = ~is_r_s;
        alu_op_s    = alu_code_s;
        if (is_load_s || is_store_s) begin
          state_nxt_s = ST_MEMORY;
        end else if (is_r_s || is_i_s) begin
          state_nxt_s = ST_WRITEBACK;
        end else begin
          state_nxt_s = ST_TRAP;
        end
      end
      ST_MEMORY: begin
        mem_req_s = 1'b1;
        mem_we_s  = is_store_s;
        if (mem.mem_ready) begin
          if (is_store_s) begin
            state_nxt_s = ST_FETCH;
            retire_s    = 1'b1;
          end else begin
            state_nxt_s = ST_WRITEBACK;
          end
        end else if (wait_r == WAIT_LAST) begin
          state_nxt_s = ST_TRAP;
        end else begin
          state_nxt_s = ST_MEMORY;
        end
      end
      ST_WRITEBACK: begin
        reg_write_s = 1'b1;
        wb_sel_s    = is_load_s;
        alu_op_s    = alu_code_s;
        state_nxt_s = ST_FETCH;
        retire_s    = 1'b1;
      end
      ST_TRAP: begin
        state_nxt_s = ST_TRAP;
      end
      default: begin
        // Unused codes 6 and 7 fall into TRAP.
        state_nxt_s = ST_TRAP;
      end
    endcase
  end

  // State, latched fields, wait counter, trap flag and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_FETCH;
      op_r      <= 7'b0000000;
      f3_r      <= 3'b000;
      f75_r     <= 1'b0;
      wait_r    <= '0;
      illegal_r <= 1'b0;
      retired_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_DECODE) begin
        op_r  <= opcode;
        f3_r  <= funct3;
        f75_r <= funct7_5;
      end
      // Any state change clears the counter, so it starts at 0 on entry.
      if (state_nxt_s != state_r) begin
        wait_r <= '0;
      end else if (waiting_s && !mem.mem_ready) begin
        wait_r <= wait_r + WAIT_W'(1);
      end
      if (state_nxt_s == ST_TRAP) begin
        illegal_r <= 1'b1;
      end
      if (retire_s) begin
        retired_r <= retired_r + CNT_W'(1);
      end
    end
  end

  assign mem.mem_req = mem_req_s;
  assign mem.mem_we  = mem_we_s;
  assign ir_write    = ir_write_s;
  assign pc_write    = pc_write_s;
  assign alu_src_b   = alu_src_b_s;
  assign alu_op      = ALU_OP_W'(alu_op_s);
  assign reg_write   = reg_write_s;
  assign wb_sel      = wb_sel_s;
  assign state       = state_r;
  assign illegal     = illegal_r;
  assign retired     = retired_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (TIMEOUT=4, CNT_W=2, ALU_OP_W=6).
// Each instruction is expanded into an expected per-cycle trace from the
// instruction-level rules, then replayed cycle by cycle with checks.
module tb_multicycle_control_unit;
  localparam int TO = 4;
  localparam int CW = 2;
  localparam int AW = 6;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BAD = 7'b1110011;

  logic          clk;
  logic          rst;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          funct7_5;
  logic          ir_write, pc_write, alu_src_b, reg_write, wb_sel, illegal;
  logic [AW-1:0] alu_op;
  logic [2:0]    state;
  logic [CW-1:0] retired;

  multicycle_control_unit_if mem_bus();

  multicycle_control_unit #(.ALU_OP_W(AW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .mem(mem_bus),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .ir_write(ir_write), .pc_write(pc_write), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel),
    .state(state), .illegal(illegal), .retired(retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit rst; bit rdy; logic [6:0] op; logic [2:0] f3; bit f75; bit en;
    int st; bit req; bit we; bit irw; bit pcw; bit srcb; int alu;
    bit rw; bit wbs; bit ill; int ret;
  } cyc_t;

  cyc_t q[$];
  int   m_ret = 0;
  bit   m_ill = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   obs_states[$];
  int   exec_alu[$];
  int   n_rw, n_mem_rd, n_we, n_wbs;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int exp_alu(input logic [6:0] op, input logic [2:0] f3, input bit f75);
    if (op == OP_R) return int'({f75, f3});
    if (op == OP_I) return (f3 == 3'b101) ? int'({f75, f3}) : int'(f3);
    return 0;
  endfunction

  function automatic cyc_t base(input int st);
    cyc_t c;
    c.rst = 1'b0; c.rdy = 1'b1; c.op = 7'b1111111; c.f3 = 3'b111; c.f75 = 1'b1;
    c.en = 1'b1; c.st = st; c.req = 1'b0; c.we = 1'b0; c.irw = 1'b0; c.pcw = 1'b0;
    c.srcb = 1'b0; c.alu = 0; c.rw = 1'b0; c.wbs = 1'b0; c.ill = m_ill; c.ret = m_ret;
    return c;
  endfunction

  task automatic retire();
    m_ret = (m_ret + 1) % (1 << CW);
  endtask

  task automatic plan_reset();
    cyc_t c;
    c = base(0);
    c.rst = 1'b1;
    c.en = 1'b0;
    q.push_back(c);
    m_ret = 0;
    m_ill = 1'b0;
  endtask

  task automatic plan_trap(input int n);
    cyc_t c;
    m_ill = 1'b1;
    for (int i = 0; i < n; i++) begin
      c = base(5);
      c.rdy = (i % 2 == 0);
      q.push_back(c);
    end
  endtask

  // flat/mlat: cycle on which memory answers (beyond TO means never);
  // abort_at: MEMORY cycle on which reset is applied (0 = none).
  task automatic plan_instr(input logic [6:0] op, input logic [2:0] f3, input bit f75,
                            input int flat, input int mlat, input int abort_at);
    cyc_t c;
    bit is_r, is_i, is_ld, is_st;
    is_r = (op == OP_R); is_i = (op == OP_I); is_ld = (op == OP_LD); is_st = (op == OP_ST);
    for (int i = 1; i <= TO; i++) begin
      c = base(0);
      c.req = 1'b1; c.rdy = (i == flat); c.irw = c.rdy; c.pcw = c.rdy;
      q.push_back(c);
      if (i == flat) break;
    end
    if (flat > TO) begin plan_trap(10); return; end
    c = base(1);
    c.op = op; c.f3 = f3; c.f75 = f75;
    q.push_back(c);
    if (!(is_r || is_i || is_ld || is_st)) begin plan_trap(10); return; end
    c = base(2);
    c.srcb = !is_r; c.alu = exp_alu(op, f3, f75);
    q.push_back(c);
    if (is_ld || is_st) begin
      for (int i = 1; i <= TO; i++) begin
        c = base(3);
        c.req = 1'b1; c.we = is_st; c.rdy = (i == mlat);
        if (i == abort_at) begin
          c.rst = 1'b1;
          q.push_back(c);
          m_ret = 0;
          m_ill = 1'b0;
          return;
        end
        q.push_back(c);
        if (i == mlat) break;
      end
      if (mlat > TO) begin plan_trap(10); return; end
      if (is_st) begin retire(); return; end
    end
    c = base(4);
    c.rw = 1'b1; c.wbs = is_ld; c.alu = exp_alu(op, f3, f75);
    q.push_back(c);
    retire();
  endtask

  task automatic clr_obs();
    obs_states.delete(); exec_alu.delete();
    n_rw = 0; n_mem_rd = 0; n_we = 0; n_wbs = 0;
  endtask

  function automatic int count_state(input int s);
    int n = 0;
    foreach (obs_states[i]) if (obs_states[i] == s) n++;
    return n;
  endfunction

  // Replays the planned trace: drive after the rising edge, check on the falling edge.
  task automatic run_q();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      rst = c.rst; mem_bus.mem_ready = c.rdy;
      opcode = c.op; funct3 = c.f3; funct7_5 = c.f75;
      @(negedge clk);
      if (c.en) begin
        chk("state",     32'(state),            32'(c.st));
        chk("mem_req",   32'(mem_bus.mem_req),  32'(c.req));
        chk("mem_we",    32'(mem_bus.mem_we),   32'(c.we));
        chk("ir_write",  32'(ir_write),         32'(c.irw));
        chk("pc_write",  32'(pc_write),         32'(c.pcw));
        chk("alu_src_b", 32'(alu_src_b),        32'(c.srcb));
        chk("alu_op",    32'(alu_op),           32'(c.alu));
        chk("reg_write", 32'(reg_write),        32'(c.rw));
        chk("wb_sel",    32'(wb_sel),           32'(c.wbs));
        chk("illegal",   32'(illegal),          32'(c.ill));
        chk("retired",   32'(retired),          32'(c.ret));
      end
      obs_states.push_back(int'(state));
      if (reg_write === 1'b1) n_rw++;
      if (state === 3'd2) exec_alu.push_back(int'(alu_op));
      if (state === 3'd3 && mem_bus.mem_req === 1'b1 && mem_bus.mem_we === 1'b0) n_mem_rd++;
      if (mem_bus.mem_we === 1'b1) n_we++;
      if (wb_sel === 1'b1) n_wbs++;
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_bus.mem_ready = 1'b0;
    opcode = 7'b0000000; funct3 = 3'b000; funct7_5 = 1'b0;
    @(posedge clk);
    #1;

    plan_reset(); plan_reset(); run_q();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_mem_req", 32'(mem_bus.mem_req), 32'd1);

    // R-type SUB, memory answers on first fetch cycle.
    clr_obs(); plan_instr(OP_R, 3'b000, 1'b1, 1, 0, 0); run_q();
    chk("r_len", 32'(obs_states.size()), 32'd4);
    chk("r_s1", 32'(obs_states[1]), 32'd1);
    chk("r_s2", 32'(obs_states[2]), 32'd2);
    chk("r_s3", 32'(obs_states[3]), 32'd4);
    chk("r_alu", 32'(exec_alu[0]), 32'd8);
    chk("r_rw", 32'(n_rw), 32'd1);
    chk("r_ret", 32'(retired), 32'd1);
    chk("r_back_fetch", 32'(state), 32'd0);

    // LOAD with 3-cycle memory wait.
    clr_obs(); plan_instr(OP_LD, 3'b010, 1'b0, 2, 3, 0); run_q();
    chk("ld_mem_cycles", 32'(n_mem_rd), 32'd3);
    chk("ld_wbs", 32'(n_wbs), 32'd1);
    chk("ld_rw", 32'(n_rw), 32'd1);
    chk("ld_ret", 32'(retired), 32'd2);

    // STORE goes straight back to FETCH.
    clr_obs(); plan_instr(OP_ST, 3'b010, 1'b0, 1, 2, 0); run_q();
    chk("st_we", 32'(n_we), 32'd2);
    chk("st_rw", 32'(n_rw), 32'd0);
    chk("st_ret", 32'(retired), 32'd3);
    chk("st_fetch", 32'(state), 32'd0);

    // SRAI: fourth retirement wraps the 2-bit counter.
    clr_obs(); plan_instr(OP_I, 3'b101, 1'b1, 1, 0, 0); run_q();
    chk("srai_alu", 32'(exec_alu[0]), 32'd13);
    chk("wrap_ret", 32'(retired), 32'd0);

    // ADDI ignores funct7_5; AND keeps funct3.
    clr_obs();
    plan_instr(OP_I, 3'b000, 1'b1, 1, 0, 0);
    plan_instr(OP_R, 3'b111, 1'b0, 1, 0, 0);
    run_q();
    chk("e_n", 32'(exec_alu.size()), 32'd2);
    chk("addi_alu", 32'(exec_alu[0]), 32'd0);
    chk("and_alu", 32'(exec_alu[1]), 32'd7);
    chk("e_ret", 32'(retired), 32'd2);

    // Illegal opcode traps from DECODE and holds.
    clr_obs(); plan_instr(OP_BAD, 3'b000, 1'b0, 1, 0, 0); run_q();
    chk("ill_trap_cycles", 32'(count_state(5)), 32'd10);
    chk("ill_rw", 32'(n_rw), 32'd0);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_state", 32'(state), 32'd5);
    plan_reset(); run_q();
    chk("ill_rst_state", 32'(state), 32'd0);
    chk("ill_rst_flag", 32'(illegal), 32'd0);

    // Fetch timeout after exactly TO cycles.
    clr_obs(); plan_instr(OP_R, 3'b000, 1'b0, TO + 1, 0, 0); run_q();
    chk("to_fetch_cycles", 32'(count_state(0)), 32'd4);
    chk("to_then_trap", 32'(obs_states[4]), 32'd5);
    plan_reset(); run_q();

    // Ready on the last permitted fetch cycle wins.
    clr_obs(); plan_instr(OP_R, 3'b000, 1'b0, TO, 0, 0); run_q();
    chk("edge_no_trap", 32'(count_state(5)), 32'd0);
    chk("edge_ret", 32'(retired), 32'd1);

    // Reset in the middle of a STORE's MEMORY phase: not retired.
    clr_obs(); plan_instr(OP_ST, 3'b010, 1'b0, 1, 100, 2); run_q();
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_ret", 32'(retired), 32'd0);
    chk("abort_req", 32'(mem_bus.mem_req), 32'd1);

    // LOAD answered on last permitted MEMORY cycle, then a LOAD that times out.
    clr_obs(); plan_instr(OP_LD, 3'b000, 1'b0, 1, TO, 0); run_q();
    chk("mem_edge_ret", 32'(retired), 32'd1);
    clr_obs(); plan_instr(OP_LD, 3'b000, 1'b0, 1, TO + 1, 0); run_q();
    chk("mem_to_cycles", 32'(count_state(3)), 32'd4);
    chk("mem_to_flag", 32'(illegal), 32'd1);
    plan_reset(); run_q();
    chk("final_state", 32'(state), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter ALU_OP_W, default 4: width of alu_op; SHALL be >= 4, upper bits beyond 4 driven 0.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles waiting for mem_ready before trap; SHALL be >= 2.
REQ-003 Parameter CNT_W, default 32: width of retired-instruction counter.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 opcode  input  7  instruction opcode from instruction register; sampled in DECODE.
REQ-007 funct3  input  3  instruction funct3; sampled in DECODE.
REQ-008 funct7_5  input  1  instruction bit 30; sampled in DECODE.
REQ-009 mem_ready  input  1  memory completion strobe for the current mem_req.
REQ-010 mem_req  output  1  memory access request, held until mem_ready.
REQ-011 mem_we  output  1  write qualifier, valid only with mem_req.
REQ-012 ir_write / pc_write  output  1 each  load instruction register / advance PC by 4.
REQ-013 alu_src_b  output  1  0 = register rs2, 1 = immediate.
REQ-014 alu_op  output  ALU_OP_W  ALU operation code.
REQ-015 reg_write  output  1  register-file write enable.
REQ-016 wb_sel  output  1  0 = ALU result, 1 = memory data.
REQ-017 state  output  3  current FSM state encoding.
REQ-018 illegal  output  1  sticky trap flag.
REQ-019 retired  output  CNT_W  count of completed instructions.

Function
REQ-020 States SHALL be FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=5; codes 6-7 SHALL transition to TRAP next cycle.
REQ-021 FETCH: mem_req=1, mem_we=0; on mem_ready, ir_write=1 and pc_write=1 for exactly that cycle, next state DECODE.
REQ-022 DECODE: lasts exactly one cycle; latches opcode, funct3, funct7_5 into internal registers; next state EXECUTE for opcodes 0110011 (R), 0010011 (I-ALU), 0000011 (LOAD), 0100011 (STORE); any other opcode goes to TRAP.
REQ-023 EXECUTE: one cycle; alu_src_b=0 for R, 1 otherwise; next state WRITEBACK for R/I-ALU, MEMORY for LOAD/STORE.
REQ-024 alu_op[3:0] SHALL be {funct7_5,funct3} for R; {funct7_5,funct3} for I-ALU when funct3=101, else {0,funct3}; 0000 for LOAD/STORE; driven in EXECUTE and WRITEBACK, 0 elsewhere.
REQ-025 MEMORY: mem_req=1, mem_we=1 for STORE, 0 for LOAD; on mem_ready LOAD goes to WRITEBACK, STORE goes to FETCH and retires.
REQ-026 WRITEBACK: one cycle; reg_write=1; wb_sel=1 for LOAD, 0 otherwise; next state FETCH and retires.
REQ-027 Retire: retired SHALL increment by 1 on the transition-out edge defined above, wrapping modulo 2^CNT_W.
REQ-028 Timeout: a wait counter SHALL clear on entering FETCH or MEMORY and increment each cycle mem_ready=0 there; when TIMEOUT consecutive cycles elapse without mem_ready, next state TRAP; mem_ready on the final permitted cycle SHALL win over timeout.
REQ-029 TRAP: all strobes (mem_req, ir_write, pc_write, reg_write) 0; illegal=1; state held until rst.
REQ-030 mem_ready outside FETCH/MEMORY SHALL be ignored.
REQ-031 All outputs not named active in a state SHALL be 0 in that state.

Reset
REQ-032 rst=1 at a clock edge SHALL force state=FETCH, illegal=0, retired=0, wait counter=0, latched fields=0, regardless of current state including mid-MEMORY or TRAP.
REQ-033 The cycle after reset deassertion SHALL present mem_req=1 in FETCH; a pending memory access aborted by reset is not retired.

Verification
REQ-034 R-type: opcode 0110011, funct3 000, funct7_5 1, mem_ready in 1st FETCH cycle -> states 0,1,2,4,0; alu_op=1000; reg_write=1 one cycle; retired 0->1.
REQ-035 LOAD with 3-cycle memory wait: opcode 0000011 -> MEMORY holds mem_req=1,mem_we=0 for 3 cycles, then WRITEBACK with wb_sel=1, reg_write=1; retired +1.
REQ-036 STORE: opcode 0100011 -> MEMORY with mem_we=1, then FETCH directly; reg_write never asserted; retired +1.
REQ-037 Illegal opcode 1110011 -> DECODE to TRAP; illegal=1 held 10 cycles with all strobes 0; rst -> state 0, illegal 0.
REQ-038 Timeout: TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP after exactly 4 cycles; repeat with mem_ready on 4th cycle -> DECODE, no trap.
REQ-039 Reset mid-MEMORY of a STORE and counter wrap: CNT_W=2, retire 4 instructions -> retired=0; rst during MEMORY -> FETCH next cycle, retired=0.
